// File: rtl/sudoku_pkg.sv
// Shared types and helpers for the Sudoku result checker: grid geometry,
// cell/grid types, error codes, FSM states and box-coordinate helpers.
package sudoku_pkg;

    localparam int N      = 9;
    localparam int BOX    = 3;
    localparam int CELL_W = 4;

    localparam logic [3:0] LAST_UNIT = 4'(N - 1);

    typedef logic [CELL_W-1:0] cell_t;
    typedef cell_t grid_t [N][N];

    typedef enum logic [2:0] {
        ERR_NONE  = 3'd0,
        ERR_CLUE  = 3'd1,
        ERR_RANGE = 3'd2,
        ERR_ROW   = 3'd3,
        ERR_COL   = 3'd4,
        ERR_BOX   = 3'd5
    } err_code_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLUES,
        ST_ROWS,
        ST_COLS,
        ST_BOXES,
        ST_DONE
    } chk_state_e;

    // Box b, cell j (row-major inside the box) -> grid row / column.
    function automatic logic [3:0] box_row(input logic [3:0] b, input logic [3:0] j);
        return 4'((b / 4'd3) * 4'd3 + j / 4'd3);
    endfunction

    function automatic logic [3:0] box_col(input logic [3:0] b, input logic [3:0] j);
        return 4'((b % 4'd3) * 4'd3 + j % 4'd3);
    endfunction

    function automatic chk_state_e next_phase(input chk_state_e s);
        case (s)
            ST_CLUES: return ST_ROWS;
            ST_ROWS:  return ST_COLS;
            ST_COLS:  return ST_BOXES;
            default:  return ST_DONE;
        endcase
    endfunction

endpackage

// File: rtl/sudoku_unit_check.sv
// Combinational check of one 9-cell unit (row, column or box): optional
// range check plus duplicate detection via a one-hot seen-mask prefix chain.
module sudoku_unit_check
    import sudoku_pkg::*;
#(
    parameter int CELL_W = 4
) (
    input  logic [CELL_W-1:0] cells [N],
    input  logic              range_en,
    output logic              range_err,
    output logic              dup_err,
    output logic [3:0]        first_bad_idx
);

    localparam int VALS = 1 << CELL_W;

    logic [VALS-1:0] seen [N+1];
    logic [N-1:0]    range_hit;
    logic [N-1:0]    dup_hit;

    // seen[i] holds every digit present in cells[0..i-1].
    always_comb begin
        seen[0] = '0;
        for (int i = 0; i < N; i++) begin
            range_hit[i] = range_en &&
                           ((cells[i] == '0) || (cells[i] > CELL_W'(N)));
            dup_hit[i]   = seen[i][cells[i]];
            seen[i+1]    = seen[i] | (VALS'(1) << cells[i]);
        end
    end

    // NOTE: every output gets a default before the conditional logic, so no
    // path leaves a variable unassigned and no latch is inferred.
    always_comb begin
        range_err     = |range_hit;
        dup_err       = |dup_hit;
        first_bad_idx = '0;
        if (range_err) begin
            for (int i = N - 1; i >= 0; i--) begin
                if (range_hit[i]) first_bad_idx = 4'(i);
            end
        end else begin
            for (int i = N - 1; i >= 0; i--) begin
                if (dup_hit[i]) first_bad_idx = 4'(i);
            end
        end
    end

endmodule

// File: rtl/sudoku_checker.sv
// Snapshots a puzzle and its solved grid on start, then scans clues, rows,
// columns and boxes one unit per cycle and reports a verdict and first error.
module sudoku_checker
    import sudoku_pkg::*;
#(
    parameter int CELL_W     = 4,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              start,
    input  logic [CELL_W-1:0] in_grid     [N][N],
    input  logic [CELL_W-1:0] solved_grid [N][N],
    output logic              busy,
    output logic              done,
    output logic              valid,
    output logic [2:0]        err_code,
    output logic [3:0]        err_unit,
    output logic [3:0]        err_cell
);

    chk_state_e        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [CELL_W-1:0] in_snap  [N][N];
    logic [CELL_W-1:0] sol_snap [N][N];
    err_code_e         err_q;
    logic [3:0]        err_unit_q, err_cell_q;
    logic              valid_q;

    logic              scanning;
    logic              start_acc;

    logic [CELL_W-1:0] unit_cells [N];
    logic              range_err, dup_err;
    logic [3:0]        unit_idx;

    logic [N-1:0]      clue_hit;
    logic [3:0]        clue_idx;

    logic              cur_err;
    err_code_e         cur_code;
    logic [3:0]        cur_idx;

    assign scanning  = (state_q == ST_CLUES) || (state_q == ST_ROWS) ||
                       (state_q == ST_COLS)  || (state_q == ST_BOXES);
    assign start_acc = (state_q == ST_IDLE) && start;

    // Present the current row, column or box to the shared unit checker.
    always_comb begin
        for (int j = 0; j < N; j++) begin
            unit_cells[j] = sol_snap[cnt_q][j];
            if (state_q == ST_COLS) begin
                unit_cells[j] = sol_snap[j][cnt_q];
            end else if (state_q == ST_BOXES) begin
                unit_cells[j] = sol_snap[box_row(cnt_q, 4'(j))][box_col(cnt_q, 4'(j))];
            end
        end
    end

    sudoku_unit_check #(
        .CELL_W (CELL_W)
    ) u_unit_check (
        .cells         (unit_cells),
        .range_en      (state_q == ST_ROWS),
        .range_err     (range_err),
        .dup_err       (dup_err),
        .first_bad_idx (unit_idx)
    );

    // A blank puzzle cell places no constraint on the solution.
    always_comb begin
        clue_idx = '0;
        for (int j = 0; j < N; j++) begin
            clue_hit[j] = (in_snap[cnt_q][j] != '0) &&
                          (sol_snap[cnt_q][j] != in_snap[cnt_q][j]);
        end
        for (int j = N - 1; j >= 0; j--) begin
            if (clue_hit[j]) clue_idx = 4'(j);
        end
    end

    always_comb begin
        cur_err  = 1'b0;
        cur_code = ERR_NONE;
        cur_idx  = unit_idx;
        unique case (state_q)
            ST_CLUES: begin
                cur_err  = |clue_hit;
                cur_code = ERR_CLUE;
                cur_idx  = clue_idx;
            end
            ST_ROWS: begin
                cur_err  = range_err || dup_err;
                cur_code = range_err ? ERR_RANGE : ERR_ROW;
            end
            ST_COLS: begin
                cur_err  = dup_err;
                cur_code = ERR_COL;
            end
            ST_BOXES: begin
                cur_err  = dup_err;
                cur_code = ERR_BOX;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_CLUES;
                    cnt_d   = '0;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: begin
                cnt_d = (cnt_q == LAST_UNIT) ? '0 : cnt_q + 4'd1;
                if (EARLY_EXIT && cur_err) begin
                    state_d = ST_DONE;
                end else if (cnt_q == LAST_UNIT) begin
                    state_d = next_phase(state_q);
                end
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // values from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            err_q      <= ERR_NONE;
            err_unit_q <= '0;
            err_cell_q <= '0;
            valid_q    <= 1'b0;
            // NOTE: the snapshot arrays are cleared on reset so a check never
            // sees stale grid contents from before a reset.
            in_snap    <= '{default: '0};
            sol_snap   <= '{default: '0};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (start_acc) begin
                in_snap    <= in_grid;
                sol_snap   <= solved_grid;
                err_q      <= ERR_NONE;
                err_unit_q <= '0;
                err_cell_q <= '0;
                valid_q    <= 1'b0;
            end else if (scanning) begin
                if (cur_err && (err_q == ERR_NONE)) begin
                    err_q      <= cur_code;
                    err_unit_q <= cnt_q;
                    err_cell_q <= cur_idx;
                end
                if (state_d == ST_DONE) begin
                    valid_q <= (err_q == ERR_NONE) && !cur_err;
                end
            end
        end
    end

    assign busy     = scanning;
    assign done     = (state_q == ST_DONE);
    assign valid    = valid_q;
    assign err_code = err_q;
    assign err_unit = err_unit_q;
    assign err_cell = err_cell_q;

endmodule
